// File: rtl/fpnew_i2f_cast_lanes.sv
// Multi-lane integer -> FP32 converter; NUM_PIPE_REGS-deep valid/ready pipeline (0 = combinational).
// Define FP_CAST_RMM_EN to make RMM round ties away from zero; otherwise RMM resolves as RNE.
module fpnew_i2f_cast_lanes #(
  parameter int unsigned LANES         = 2,
  parameter int unsigned INT_WIDTH     = 32,
  parameter int unsigned NUM_PIPE_REGS = 2,
  parameter int unsigned TAG_WIDTH     = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [LANES*INT_WIDTH-1:0] operands_i,
  input  logic                       op_mod_i,
  input  logic [2:0]                 rnd_mode_i,
  input  logic [TAG_WIDTH-1:0]       tag_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       flush_i,
  output logic [LANES*32-1:0]        result_o,
  output logic [4:0]                 status_o,
  output logic [TAG_WIDTH-1:0]       tag_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic                       busy_o
);

  localparam int unsigned NW = INT_WIDTH + 25;
  localparam logic [2:0] RNE = 3'b000;
  localparam logic [2:0] RTZ = 3'b001;
  localparam logic [2:0] RDN = 3'b010;
  localparam logic [2:0] RUP = 3'b011;
`ifdef FP_CAST_RMM_EN
  localparam logic [2:0] RMM = 3'b100;
`endif

  typedef struct packed {
    logic          sign;
    logic          zero;
    logic [7:0]    exp;
    logic [NW-1:0] man;
  } norm_t;

  typedef struct packed {
    norm_t [LANES-1:0]    lane;
    logic [2:0]           rnd;
    logic [TAG_WIDTH-1:0] tag;
  } mid_t;

  typedef struct packed {
    logic [LANES*32-1:0]  res;
    logic [4:0]           status;
    logic [TAG_WIDTH-1:0] tag;
  } out_t;

  // Leading one is moved to the top of a field padded with 25 zeros, so the
  // 24 kept bits, guard and sticky sit at fixed positions for any INT_WIDTH.
  function automatic norm_t normalize(input logic [INT_WIDTH-1:0] x, input logic is_unsigned);
    norm_t                n;
    logic [INT_WIDTH-1:0] mag;
    int unsigned          lz;
    n.sign = ~is_unsigned & x[INT_WIDTH-1];
    mag    = n.sign ? -x : x;
    lz     = INT_WIDTH;
    for (int i = 0; i < INT_WIDTH; i++)
      if (mag[i]) lz = INT_WIDTH - 1 - i;
    n.zero = (mag == '0);
    n.exp  = 8'(127 + INT_WIDTH - 1 - lz);
    n.man  = {mag, 25'b0} << lz;
    return n;
  endfunction

  // Returns {nx, fp32}.
  function automatic logic [32:0] round_lane(input norm_t n, input logic [2:0] rnd);
    logic [23:0] kept;
    logic        g, s, up, rne_up;
    logic [24:0] sum;
    logic [7:0]  e;
    kept   = n.man[NW-1 -: 24];
    g      = n.man[NW-25];
    s      = |n.man[NW-26:0];
    rne_up = g & (s | kept[0]);
    case (rnd)
      RNE:     up = rne_up;
      RTZ:     up = 1'b0;
      RDN:     up = n.sign & (g | s);
      RUP:     up = ~n.sign & (g | s);
`ifdef FP_CAST_RMM_EN
      RMM:     up = g;
`endif
      default: up = rne_up;
    endcase
    sum = {1'b0, kept} + 25'(up);
    e   = n.exp + 8'(sum[24]);
    return {g | s, n.zero ? 32'h0 : {n.sign, e, sum[22:0]}};
  endfunction

  function automatic out_t finish(input mid_t m);
    out_t        o;
    logic [32:0] r;
    o = '0;
    for (int k = 0; k < LANES; k++) begin
      r = round_lane(m.lane[k], m.rnd);
      o.res[k*32 +: 32] = r[31:0];
      o.status[0] |= r[32];
    end
    o.tag = m.tag;
    return o;
  endfunction

  mid_t mid_in;
  always_comb begin
    mid_in = '0;
    for (int k = 0; k < LANES; k++)
      mid_in.lane[k] = normalize(operands_i[k*INT_WIDTH +: INT_WIDTH], op_mod_i);
    mid_in.rnd = rnd_mode_i;
    mid_in.tag = tag_i;
  end

  if (NUM_PIPE_REGS == 0) begin : g_comb
    out_t out_c;
    assign out_c       = finish(mid_in);
    assign result_o    = out_c.res;
    assign status_o    = out_c.status;
    assign tag_o       = out_c.tag;
    assign out_valid_o = in_valid_i;
    assign in_ready_o  = out_ready_i;
    assign busy_o      = 1'b0;
  end else begin : g_pipe
    localparam int N = NUM_PIPE_REGS;
    logic [N:1]   vld_q;
    logic [N:0]   vld;
    logic [N+1:1] rdy;
    mid_t         last_mid;
    out_t         out_q;

    assign vld = {vld_q, in_valid_i};

    always_comb begin
      rdy      = '0;
      rdy[N+1] = out_ready_i;
      for (int i = N; i >= 1; i--) rdy[i] = ~vld[i] | rdy[i+1];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)      vld_q <= '0;
      else if (flush_i) vld_q <= '0;
      else
        for (int i = 1; i <= N; i++)
          if (rdy[i]) vld_q[i] <= vld[i-1];
    end

    if (N >= 2) begin : g_mid
      mid_t mid_q [1:N-1];
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 1; i < N; i++) mid_q[i] <= '0;
        end else begin
          if (rdy[1] && vld[0]) mid_q[1] <= mid_in;
          for (int i = 2; i < N; i++)
            if (rdy[i] && vld[i-1]) mid_q[i] <= mid_q[i-1];
        end
      end
      assign last_mid = mid_q[N-1];
    end else begin : g_nomid
      assign last_mid = mid_in;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                out_q <= '0;
      else if (rdy[N] && vld[N-1]) out_q <= finish(last_mid);
    end

    assign result_o    = out_q.res;
    assign status_o    = out_q.status;
    assign tag_o       = out_q.tag;
    assign out_valid_o = vld_q[N];
    // A flushing cycle swallows the offered beat, so it is reported as taken.
    assign in_ready_o  = rdy[1] | flush_i;
    assign busy_o      = |vld_q;
  end

endmodule

// File: tb/tb_fpnew_i2f_cast_lanes.sv
// Scoreboard bench for fpnew_i2f_cast_lanes: directed vectors, decoupled driver and monitor.
module tb_fpnew_i2f_cast_lanes;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [63:0] operands;
  logic        op_mod;
  logic [2:0]  rnd_mode;
  logic [2:0]  tag;
  logic        in_valid;
  logic        in_ready_o;
  logic        flush;
  logic [63:0] result_o;
  logic [4:0]  status_o;
  logic [2:0]  tag_o;
  logic        out_valid_o;
  logic        out_ready;
  logic        busy_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  st;
    logic [2:0]  tag;
    int          cyc;
    bit          lat;
  } exp_t;
  exp_t q[$];

`ifdef FP_CAST_RMM_EN
  localparam logic [31:0] RMM_TIE = 32'h4B800001;
`else
  localparam logic [31:0] RMM_TIE = 32'h4B800000;
`endif

  fpnew_i2f_cast_lanes #(
    .LANES(2), .INT_WIDTH(32), .NUM_PIPE_REGS(2), .TAG_WIDTH(3)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .operands_i(operands), .op_mod_i(op_mod),
    .rnd_mode_i(rnd_mode), .tag_i(tag), .in_valid_i(in_valid), .in_ready_o(in_ready_o),
    .flush_i(flush), .result_o(result_o), .status_o(status_o), .tag_o(tag_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni && out_valid_o && out_ready) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat: result=%h tag=%0d, required no output", result_o, tag_o);
      end else begin
        e = q.pop_front();
        if (result_o !== e.res || status_o !== e.st || tag_o !== e.tag) begin
          n_err++;
          $display("FAIL beat_data: result=%h status=%b tag=%0d, required result=%h status=%b tag=%0d",
                   result_o, status_o, tag_o, e.res, e.st, e.tag);
        end
        if (e.lat) begin
          n_vec++;
          if (cyc - e.cyc != 2) begin
            n_err++;
            $display("FAIL latency: got %0d cycles, required 2", cyc - e.cyc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic send(input logic [31:0] a0, input logic [31:0] a1, input logic mod,
                      input logic [2:0] rnd, input logic [2:0] tg, input logic [31:0] e0,
                      input logic [31:0] e1, input logic nx, input bit push, input bit lat);
    int guard;
    guard    = 0;
    operands = {a1, a0};
    op_mod   = mod;
    rnd_mode = rnd;
    tag      = tg;
    in_valid = 1'b1;
    @(negedge clk_i);
    while (!in_ready_o && guard < 100) begin
      @(negedge clk_i);
      guard++;
    end
    if (!in_ready_o) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: in_ready_o=%0b, required 1", in_ready_o);
    end else if (push) begin
      q.push_back('{res: {e1, e0}, st: {4'b0, nx}, tag: tg, cyc: cyc, lat: lat});
    end
    @(posedge clk_i); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 100) begin
      @(negedge clk_i);
      guard++;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", q.size());
    end
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [31:0] pos_tab [6];
    logic [31:0] neg_tab [6];
    pos_tab = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
    neg_tab = '{32'hBF800000, 32'hC0000000, 32'hC0400000, 32'hC0800000, 32'hC0A00000, 32'hC0C00000};

    rst_ni = 1'b0; operands = '0; op_mod = 1'b0; rnd_mode = 3'b000; tag = '0;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_out_valid", 64'(out_valid_o), 64'd0);
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    check("reset_status_tag", 64'({status_o, tag_o}), 64'd0);
    check("reset_in_ready", 64'(in_ready_o), 64'd1);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Directed conversions: lane0, lane1, signedness, mode, tag, expected lanes, NX.
    send(32'h00000001, 32'hFFFFFFFF, 1'b0, 3'b000, 3'd1, 32'h3F800000, 32'hBF800000, 1'b0, 1, 1);
    send(32'h80000000, 32'h00000000, 1'b0, 3'b000, 3'd2, 32'hCF000000, 32'h00000000, 1'b0, 1, 1);
    send(32'hFFFFFFFF, 32'h00000001, 1'b1, 3'b000, 3'd3, 32'h4F800000, 32'h3F800000, 1'b1, 1, 1);
    send(32'h01000001, 32'h01000003, 1'b0, 3'b000, 3'd4, 32'h4B800000, 32'h4B800002, 1'b1, 1, 1);
    send(32'h01000001, 32'hFEFFFFFF, 1'b0, 3'b011, 3'd5, 32'h4B800001, 32'hCB800000, 1'b1, 1, 1);
    send(32'h01000001, 32'hFEFFFFFF, 1'b0, 3'b010, 3'd6, 32'h4B800000, 32'hCB800001, 1'b1, 1, 1);
    send(32'h01000001, 32'h7FFFFFFF, 1'b0, 3'b001, 3'd7, 32'h4B800000, 32'h4EFFFFFF, 1'b1, 1, 1);
    send(32'h01000003, 32'h01000001, 1'b0, 3'b100, 3'd0, 32'h4B800002, RMM_TIE,      1'b1, 1, 1);
    send(32'h01FFFFFF, 32'h7FFFFFFF, 1'b0, 3'b000, 3'd1, 32'h4C000000, 32'h4F000000, 1'b1, 1, 1);
    send(32'h01000001, 32'h01000003, 1'b0, 3'b101, 3'd2, 32'h4B800000, 32'h4B800002, 1'b1, 1, 1);
    send(32'h00000000, 32'h00000000, 1'b1, 3'b011, 3'd3, 32'h00000000, 32'h00000000, 1'b0, 1, 1);
    drain();

    // Backpressure: output blocked for 5 cycles while 6 beats are offered.
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 6; k++)
          send(32'(k + 1), -32'(k + 1), 1'b0, 3'b000, 3'(k), pos_tab[k], neg_tab[k], 1'b0, 1, 0);
      end
      begin
        repeat (4) @(negedge clk_i);
        check("stall_in_ready", 64'(in_ready_o), 64'd0);
        check("stall_out_valid", 64'(out_valid_o), 64'd1);
        @(posedge clk_i); #2;
        out_ready = 1'b1;
      end
    join
    drain();

    // Flush with two beats in flight and a third offered on the flush edge.
    out_ready = 1'b0;
    send(32'h00000005, 32'h00000006, 1'b0, 3'b000, 3'd5, 32'h0, 32'h0, 1'b0, 0, 0);
    send(32'h00000007, 32'h00000008, 1'b0, 3'b000, 3'd6, 32'h0, 32'h0, 1'b0, 0, 0);
    operands = {32'd10, 32'd9};
    tag      = 3'd7;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk_i);
    check("flush_in_ready", 64'(in_ready_o), 64'd1);
    @(posedge clk_i); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk_i);
    check("flush_out_valid", 64'(out_valid_o), 64'd0);
    check("flush_busy", 64'(busy_o), 64'd0);
    @(posedge clk_i); #1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk_i);
    #1;

    // Asynchronous reset in the middle of a stalled stream.
    out_ready = 1'b0;
    send(32'h00000011, 32'h00000012, 1'b0, 3'b000, 3'd1, 32'h0, 32'h0, 1'b0, 0, 0);
    send(32'h00000013, 32'h00000014, 1'b0, 3'b000, 3'd2, 32'h0, 32'h0, 1'b0, 0, 0);
    #2;
    check("pre_reset_out_valid", 64'(out_valid_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    check("async_reset_out_valid", 64'(out_valid_o), 64'd0);
    check("async_reset_busy", 64'(busy_o), 64'd0);
    @(posedge clk_i); #1;
    rst_ni    = 1'b1;
    out_ready = 1'b1;
    send(32'h7FFFFFFF, 32'h00000003, 1'b0, 3'b001, 3'd4, 32'h4EFFFFFF, 32'h40400000, 1'b1, 1, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
